// File: rtl/noc_pkg.sv
// Shared types and default widths for the 4x4 mesh NoC injection path.
package noc_pkg;

    localparam int unsigned DEF_COORD_W = 2;
    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_SEQ_W   = 8;

    // Field order matches the wire format, MSB first.
    typedef struct packed {
        logic [DEF_COORD_W-1:0] dest_x;
        logic [DEF_COORD_W-1:0] dest_y;
        logic [DEF_COORD_W-1:0] src_x;
        logic [DEF_COORD_W-1:0] src_y;
        logic [DEF_SEQ_W-1:0]   seq;
        logic [DEF_DATA_W-1:0]  data;
    } flit_t;

    typedef enum logic [0:0] {
        EMPTY,
        HOLD
    } out_state_e;

endpackage

// File: rtl/noc_inj_fifo.sv
// Synchronous FIFO buffering stamped flits between the request side and the output stage.
module noc_inj_fifo
    import noc_pkg::*;
#(
    parameter int unsigned WIDTH = $bits(flit_t),
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    // Extra MSB distinguishes full from empty when the indices match.
    logic [PTR_W:0]   wptr_q;
    logic [PTR_W:0]   rptr_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                     (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
    assign empty   = (wptr_q == rptr_q);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rptr_q[PTR_W-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + (PTR_W+1)'(1);
            if (do_pop)  rptr_q <= rptr_q + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[PTR_W-1:0]] <= wdata;
    end

endmodule

// File: rtl/noc_flit_injector.sv
// Injection-side NI: stamps local requests with source/seq, buffers them, drives the router port.
// Optional statistics counters are enabled by defining NOC_INJ_STATS_EN.
module noc_flit_injector
    import noc_pkg::*;
#(
    parameter int unsigned SRC_X       = 0,
    parameter int unsigned SRC_Y       = 0,
    parameter int unsigned COORD_W     = DEF_COORD_W,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned SEQ_W       = DEF_SEQ_W,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned STALL_LIMIT = 64
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  req_valid,
    output logic                                  req_ready,
    input  logic [COORD_W-1:0]                    req_dest_x,
    input  logic [COORD_W-1:0]                    req_dest_y,
    input  logic [DATA_W-1:0]                     req_data,
    output logic                                  flit_valid,
    input  logic                                  flit_ready,
    output logic [4*COORD_W+SEQ_W+DATA_W-1:0]     flit_data,
    input  logic                                  err_clr,
`ifdef NOC_INJ_STATS_EN
    output logic [31:0]                           sent_cnt,
    output logic [31:0]                           stall_cycles,
    output logic [15:0]                           drop_cnt,
`endif
    output logic                                  stall_err,
    output logic                                  self_err
);

    localparam int unsigned FLIT_W      = 4*COORD_W + SEQ_W + DATA_W;
    localparam int unsigned STALL_CNT_W = $clog2(STALL_LIMIT + 1);
    localparam logic [COORD_W-1:0] SRC_XC = COORD_W'(SRC_X);
    localparam logic [COORD_W-1:0] SRC_YC = COORD_W'(SRC_Y);

    out_state_e             state_q;
    logic                   flit_valid_q;
    logic [FLIT_W-1:0]      flit_q;
    logic [SEQ_W-1:0]       seq_q;
    logic [STALL_CNT_W-1:0] stall_cnt_q;
    logic                   stall_err_q;
    logic                   self_err_q;

    logic                   fifo_full;
    logic                   fifo_empty;
    logic [FLIT_W-1:0]      fifo_rdata;
    logic [FLIT_W-1:0]      fifo_wdata;

    logic req_fire;
    logic is_self;
    logic push;
    logic self_drop;
    logic accept;
    logic pop;
    logic stall;
    logic stall_hit;

    assign req_ready  = !fifo_full;
    assign req_fire   = req_valid && req_ready;
    assign is_self    = (req_dest_x == SRC_XC) && (req_dest_y == SRC_YC);
    assign push       = req_fire && !is_self;
    assign self_drop  = req_fire && is_self;
    assign accept     = flit_valid_q && flit_ready;
    assign stall      = flit_valid_q && !flit_ready;
    assign pop        = !fifo_empty && ((state_q == EMPTY) || accept);
    assign stall_hit  = stall && (stall_cnt_q == STALL_CNT_W'(STALL_LIMIT - 1));
    assign fifo_wdata = {req_dest_x, req_dest_y, SRC_XC, SRC_YC, seq_q, req_data};

    assign flit_valid = flit_valid_q;
    assign flit_data  = flit_q;
    assign stall_err  = stall_err_q;
    assign self_err   = self_err_q;

    noc_inj_fifo #(
        .WIDTH (FLIT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (fifo_wdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Output stage: the register holds the head flit until the router takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            flit_valid_q <= 1'b0;
            flit_q       <= '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (!fifo_empty) begin
                        flit_q       <= fifo_rdata;
                        flit_valid_q <= 1'b1;
                        state_q      <= HOLD;
                    end
                end
                HOLD: begin
                    if (flit_ready) begin
                        if (!fifo_empty) begin
                            flit_q <= fifo_rdata;
                        end else begin
                            flit_valid_q <= 1'b0;
                            state_q      <= EMPTY;
                        end
                    end
                end
                default: begin
                    flit_valid_q <= 1'b0;
                    state_q      <= EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_q <= '0;
        end else if (push) begin
            seq_q <= seq_q + SEQ_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (!stall) begin
            stall_cnt_q <= '0;
        end else if (stall_cnt_q != STALL_CNT_W'(STALL_LIMIT)) begin
            stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    // Set takes priority over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_err_q <= 1'b0;
            self_err_q  <= 1'b0;
        end else begin
            if (stall_hit)    stall_err_q <= 1'b1;
            else if (err_clr) stall_err_q <= 1'b0;
            if (self_drop)    self_err_q  <= 1'b1;
            else if (err_clr) self_err_q  <= 1'b0;
        end
    end

`ifdef NOC_INJ_STATS_EN
    logic [31:0] sent_cnt_q;
    logic [31:0] stall_cycles_q;
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sent_cnt_q     <= '0;
            stall_cycles_q <= '0;
            drop_cnt_q     <= '0;
        end else begin
            if (accept)    sent_cnt_q     <= sent_cnt_q + 32'd1;
            if (stall)     stall_cycles_q <= stall_cycles_q + 32'd1;
            if (self_drop) drop_cnt_q     <= drop_cnt_q + 16'd1;
        end
    end

    assign sent_cnt     = sent_cnt_q;
    assign stall_cycles = stall_cycles_q;
    assign drop_cnt     = drop_cnt_q;
`endif

endmodule
